// File: rtl/pe_array_tiled_if.sv
// Handshake and operand/result bus for the tiled element-wise multiplier.
interface pe_array_tiled_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ARRAY_SIZE = 128
);
    localparam int unsigned VEC_W = DATA_WIDTH * ARRAY_SIZE;

    logic             in_valid;
    logic             in_ready;
    logic [VEC_W-1:0] A;
    logic [VEC_W-1:0] B;
    logic             sat_mode;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] Mul;
    logic             sat_flag;
    logic             busy;

    modport master (
        output in_valid, A, B, sat_mode, out_ready,
        input  in_ready, out_valid, Mul, sat_flag, busy
    );

    modport slave (
        input  in_valid, A, B, sat_mode, out_ready,
        output in_ready, out_valid, Mul, sat_flag, busy
    );
endinterface

// File: rtl/pe_array_tiled.sv
// Element-wise signed multiplier over ARRAY_SIZE elements, ROW_SIZE lanes per cycle.
// A job is latched on accept, computed one row per cycle in RUN, and held in DONE
// until the consumer takes it.
module pe_array_tiled #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ARRAY_SIZE = 128,
    parameter int unsigned ROW_SIZE   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pe_array_tiled_if.slave   bus
);
    localparam int unsigned NUM_ROWS = ARRAY_SIZE / ROW_SIZE;
    localparam int unsigned ROW_BITS = DATA_WIDTH * ROW_SIZE;
    localparam int unsigned VEC_W    = DATA_WIDTH * ARRAY_SIZE;
    localparam int unsigned PW       = 2 * DATA_WIDTH;
    localparam int unsigned ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    if ((ARRAY_SIZE % ROW_SIZE) != 0) begin : g_bad_size
        $error("pe_array_tiled: ARRAY_SIZE must be a multiple of ROW_SIZE");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               in_ready_c;
    logic               accept_c;
    logic               run_c;
    logic               last_row_c;

    logic [VEC_W-1:0]    a_q, b_q;
    logic                sat_mode_q;
    logic                sat_flag_q;
    logic [ROW_BITS-1:0] mul_rows_q [NUM_ROWS];

    logic [ROW_BITS-1:0] a_rows_c [NUM_ROWS];
    logic [ROW_BITS-1:0] b_rows_c [NUM_ROWS];
    logic [ROW_BITS-1:0] a_row_c, b_row_c;
    logic [ROW_BITS-1:0] row_res_c;
    logic [ROW_SIZE-1:0] lane_sat_c;
    logic                row_sat_c;
    logic [VEC_W-1:0]    mul_flat_c;

    // Row views of the latched operands and of the result register (row 0 at the MSBs).
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_rows
        assign a_rows_c[r] = a_q[(NUM_ROWS-1-r)*ROW_BITS +: ROW_BITS];
        assign b_rows_c[r] = b_q[(NUM_ROWS-1-r)*ROW_BITS +: ROW_BITS];
        assign mul_flat_c[(NUM_ROWS-1-r)*ROW_BITS +: ROW_BITS] = mul_rows_q[r];
    end

    assign a_row_c    = a_rows_c[row_q];
    assign b_row_c    = b_rows_c[row_q];
    assign last_row_c = (row_q == ROW_W'(NUM_ROWS - 1));

    // One signed multiplier per lane, with optional clamp to the element range.
    for (genvar j = 0; j < ROW_SIZE; j++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] a_e, b_e;
        logic signed [PW-1:0]         prod;
        logic [DATA_WIDTH-1:0]        res;
        logic                         sat;

        assign a_e  = a_row_c[(ROW_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH];
        assign b_e  = b_row_c[(ROW_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH];
        assign prod = PW'(a_e) * PW'(b_e);

        // Truncate to the low bits, or clamp and flag when saturating.
        always_comb begin
            res = prod[DATA_WIDTH-1:0];
            sat = 1'b0;
            if (sat_mode_q) begin
                if (prod > SAT_MAX) begin
                    res = SAT_MAX[DATA_WIDTH-1:0];
                    sat = 1'b1;
                end else if (prod < SAT_MIN) begin
                    res = SAT_MIN[DATA_WIDTH-1:0];
                    sat = 1'b1;
                end
            end
        end

        assign row_res_c[(ROW_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH] = res;
        assign lane_sat_c[j] = sat;
    end

    assign row_sat_c = |lane_sat_c;

    // FSM state, row counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next state: accept in IDLE or on the DONE handshake, one row per RUN cycle.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        in_ready_c = 1'b0;
        run_c      = 1'b0;
        unique case (state_q)
            IDLE:    in_ready_c = 1'b1;
            RUN:     run_c      = 1'b1;
            DONE:    in_ready_c = bus.out_ready;
            default: state_d    = IDLE;
        endcase
        accept_c = bus.in_valid && in_ready_c;

        if (run_c) begin
            if (last_row_c) begin
                state_d = DONE;
                row_d   = '0;
            end else begin
                row_d = row_q + ROW_W'(1);
            end
        end else if (state_q == DONE && bus.out_ready) begin
            state_d = IDLE;
        end

        if (accept_c) begin
            state_d = RUN;
            row_d   = '0;
        end

        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // Operand latch on accept; row write-back and sticky saturation flag during RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            sat_mode_q <= 1'b0;
            sat_flag_q <= 1'b0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                mul_rows_q[r] <= '0;
            end
        end else if (accept_c) begin
            a_q        <= bus.A;
            b_q        <= bus.B;
            sat_mode_q <= bus.sat_mode;
            sat_flag_q <= 1'b0;
        end else if (run_c) begin
            mul_rows_q[row_q] <= row_res_c;
            sat_flag_q        <= sat_flag_q | row_sat_c;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.Mul       = mul_flat_c;
    assign bus.sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_pe_array_tiled.sv
// Scoreboard bench for pe_array_tiled at default parameters (8 rows of 16 lanes).
module tb_pe_array_tiled;
    localparam int DW = 16;
    localparam int AS = 128;
    localparam int RS = 16;
    localparam int NR = AS / RS;
    localparam int VW = DW * AS;
    localparam int MAXV = (1 << (DW - 1)) - 1;
    localparam int MINV = -(1 << (DW - 1));

    typedef struct {
        logic [VW-1:0] mul;
        logic          sat;
        int            acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;

    exp_t          sb[$];
    int            rise_q[$];
    exp_t          mon_e;
    logic          ov_prev;
    logic [VW-1:0] obs_mul;
    logic          obs_sat;

    pe_array_tiled_if #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS)) bus();

    pe_array_tiled #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .ROW_SIZE(RS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] elem(input logic [VW-1:0] v, input int i);
        return v[(AS-1-i)*DW +: DW];
    endfunction

    function automatic logic [VW-1:0] put(input logic [VW-1:0] v, input int i, input logic [DW-1:0] x);
        v[(AS-1-i)*DW +: DW] = x;
        return v;
    endfunction

    function automatic logic [VW-1:0] fill(input logic [DW-1:0] x);
        logic [VW-1:0] v;
        for (int i = 0; i < AS; i++) v[(AS-1-i)*DW +: DW] = x;
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: integer product, then truncate or clamp.
    function automatic exp_t model(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic sm);
        exp_t r;
        logic [DW-1:0] ea, eb;
        int ae, be, p;
        r.mul = '0;
        r.sat = 1'b0;
        r.acc = 0;
        for (int i = 0; i < AS; i++) begin
            ea = a[(AS-1-i)*DW +: DW];
            eb = b[(AS-1-i)*DW +: DW];
            ae = int'($signed(ea));
            be = int'($signed(eb));
            p  = ae * be;
            if (sm && p > MAXV) begin
                r.mul[(AS-1-i)*DW +: DW] = DW'(MAXV);
                r.sat = 1'b1;
            end else if (sm && p < MINV) begin
                r.mul[(AS-1-i)*DW +: DW] = DW'(MINV);
                r.sat = 1'b1;
            end else begin
                r.mul[(AS-1-i)*DW +: DW] = DW'(p);
            end
        end
        return r;
    endfunction

    // Monitor: latency on out_valid rise, compare on output handshake, push on accept.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && !ov_prev) begin
                rise_q.push_back(cyc);
                if (sb.size() == 0) check("rise_without_job", 64'(bus.out_valid), 64'(0));
                else check("latency", 64'(cyc - sb[0].acc), 64'(NR));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'(bus.out_valid), 64'(0));
                end else begin
                    mon_e = sb.pop_front();
                    for (int i = 0; i < AS; i++)
                        check($sformatf("mul[%0d]", i), 64'(elem(bus.Mul, i)), 64'(elem(mon_e.mul, i)));
                    check("sat_flag", 64'(bus.sat_flag), 64'(mon_e.sat));
                    obs_mul = bus.Mul;
                    obs_sat = bus.sat_flag;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                mon_e     = model(bus.A, bus.B, bus.sat_mode);
                mon_e.acc = cyc + 1;
                sb.push_back(mon_e);
            end
            ov_prev = bus.out_valid;
        end else begin
            ov_prev = 1'b0;
        end
    end

    // Offer a job and wait for the accept edge; keep leaves in_valid high.
    task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic sm, input bit keep);
        bit got;
        @(posedge clk); #1;
        bus.A        = a;
        bus.B        = b;
        bus.sat_mode = sm;
        bus.in_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1'b1;
        end
        if (!got) check("accept_timeout", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    // Wait until every expected result has been consumed and the block is idle.
    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy) return;
        end
        check("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [VW-1:0] a, b;
        int n0;
        bit seen;
        n_checks = 0;
        n_errors = 0;
        ov_prev  = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.sat_mode = 1'b0;
        bus.out_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk); #1;
        check("rst_mul_zero", 64'(|bus.Mul), 64'(0));
        check("rst_sat_flag", 64'(bus.sat_flag), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));

        // First job accepted on the first edge after reset release: 3 * -2
        rst_n = 1'b1;
        send(fill(DW'(3)), fill(DW'(-2)), 1'b0, 1'b0);
        check("first_accept_busy", 64'(bus.busy), 64'(1));
        @(negedge clk);
        check("run_in_ready", 64'(bus.in_ready), 64'(0));
        check("run_out_valid", 64'(bus.out_valid), 64'(0));
        drain();
        check("job1_elem0", 64'(elem(obs_mul, 0)), 64'(16'hFFFA));
        check("job1_elem127", 64'(elem(obs_mul, 127)), 64'(16'hFFFA));

        // Rows not yet rewritten keep the previous job's values
        send(fill(DW'(5)), fill(DW'(7)), 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("keep_new_e47", 64'(elem(bus.Mul, 47)), 64'(16'h0023));
        check("keep_old_e48", 64'(elem(bus.Mul, 48)), 64'(16'hFFFA));
        check("keep_old_e127", 64'(elem(bus.Mul, 127)), 64'(16'hFFFA));
        drain();

        // Saturation corners, then the same operands truncated
        a = rand_vec();
        b = rand_vec();
        a = put(a, 5, 16'h7FFF); b = put(b, 5, 16'h0002);
        a = put(a, 7, 16'h8000); b = put(b, 7, 16'h8000);
        a = put(a, 9, 16'h8000); b = put(b, 9, 16'h0002);
        send(a, b, 1'b1, 1'b0);
        drain();
        check("sat_e5", 64'(elem(obs_mul, 5)), 64'(16'h7FFF));
        check("sat_e7", 64'(elem(obs_mul, 7)), 64'(16'h7FFF));
        check("sat_e9", 64'(elem(obs_mul, 9)), 64'(16'h8000));
        check("sat_flag_set", 64'(obs_sat), 64'(1));
        send(a, b, 1'b0, 1'b0);
        drain();
        check("trunc_e5", 64'(elem(obs_mul, 5)), 64'(16'hFFFE));
        check("trunc_e9", 64'(elem(obs_mul, 9)), 64'(16'h0000));
        check("trunc_flag", 64'(obs_sat), 64'(0));

        // Back-pressure in DONE for 5 cycles
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(rand_vec(), rand_vec(), 1'b1, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("hold_reached_done", 64'(bus.out_valid), 64'(1));
        for (int k = 0; k < 5; k++) begin
            check("hold_out_valid", 64'(bus.out_valid), 64'(1));
            check("hold_in_ready", 64'(bus.in_ready), 64'(0));
            check("hold_busy", 64'(bus.busy), 64'(1));
            if (sb.size() > 0) begin
                check("hold_mul", 64'(bus.Mul === sb[0].mul), 64'(1));
                check("hold_sat", 64'(bus.sat_flag), 64'(sb[0].sat));
            end else begin
                check("hold_sb_empty", 64'(sb.size()), 64'(1));
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("single_handshake", 64'(bus.out_valid), 64'(0));
        drain();

        // Back-to-back jobs with in_valid held high
        n0 = rise_q.size();
        send(rand_vec(), rand_vec(), 1'b0, 1'b1);
        send(rand_vec(), rand_vec(), 1'b1, 1'b0);
        drain();
        if (rise_q.size() >= n0 + 2) check("b2b_gap", 64'(rise_q[n0+1] - rise_q[n0]), 64'(NR + 1));
        else check("b2b_rises", 64'(rise_q.size()), 64'(n0 + 2));

        // Reset while computing row 4, then a clean job
        send(rand_vec(), rand_vec(), 1'b1, 1'b0);
        repeat (4) @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_mul_zero", 64'(|bus.Mul), 64'(0));
        check("mid_rst_sat_flag", 64'(bus.sat_flag), 64'(0));
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_busy", 64'(bus.busy), 64'(0));
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(rand_vec(), rand_vec(), 1'b0, 1'b0);
        drain();

        // Operands change every cycle after accept
        send(rand_vec(), rand_vec(), 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            bus.A        = rand_vec();
            bus.B        = rand_vec();
            bus.sat_mode = ~bus.sat_mode;
        end
        drain();

        // A few random jobs
        for (int n = 0; n < 4; n++) begin
            send(rand_vec(), rand_vec(), 1'($urandom_range(0, 1)), 1'b0);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pe_array_tiled.md
PE_ARRAY_TILED -- requirements
Module: pe_array_tiled

Interface
REQ-001: Parameter DATA_WIDTH, default 16, element width in bits (signed two's complement).
REQ-002: Parameter ARRAY_SIZE, default 128, elements per operand vector.
REQ-003: Parameter ROW_SIZE, default 16, multipliers instantiated, i.e. elements processed per cycle; NUM_ROWS = ARRAY_SIZE/ROW_SIZE.
REQ-004: clk  input  1  the single clock; all state changes on the rising edge.
REQ-005: rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006: in_valid  input  1  operand job offered.
REQ-007: in_ready  output  1  block can accept a job this cycle.
REQ-008: A  input  DATA_WIDTH*ARRAY_SIZE  operand vector A; element 0 in the most-significant DATA_WIDTH bits.
REQ-009: B  input  DATA_WIDTH*ARRAY_SIZE  operand vector B; same packing as A.
REQ-010: sat_mode  input  1  0 = truncate product, 1 = saturate product.
REQ-011: out_valid  output  1  Mul and sat_flag hold a completed job.
REQ-012: out_ready  input  1  consumer accepts the result.
REQ-013: Mul  output  DATA_WIDTH*ARRAY_SIZE  element-wise products; same packing as A.
REQ-014: sat_flag  output  1  at least one element of the job saturated.
REQ-015: busy  output  1  high in RUN or DONE.

Function
REQ-016: FSM states are IDLE, RUN and DONE.
REQ-017: in_ready SHALL be 1 in IDLE, equal out_ready in DONE, and be 0 in RUN.
REQ-018: Accept = in_valid && in_ready; on accept, latch A, B and sat_mode internally, clear the row counter and sat_flag, and go to RUN.
REQ-019: Once a job is accepted, changes on A, B and sat_mode SHALL NOT affect it.
REQ-020: In RUN, each cycle compute row r (elements r*ROW_SIZE .. r*ROW_SIZE+ROW_SIZE-1), register it into the Mul rows it occupies, then increment r.
REQ-021: After writing row NUM_ROWS-1, go to DONE and assert out_valid; out_valid first rises NUM_ROWS cycles after the accept edge.
REQ-022: Product is the full 2*DATA_WIDTH signed product.
REQ-023: Truncate mode outputs the low DATA_WIDTH bits of the product.
REQ-024: Saturate mode clamps the product to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and ORs each clamp event into sat_flag.
REQ-025: In DONE, Mul, sat_flag and out_valid SHALL remain stable until out_ready=1.
REQ-026: On out_valid && out_ready with in_valid=1, the block SHALL accept the new job in the same cycle (go to RUN), giving back-to-back throughput of one job per NUM_ROWS+1 cycles.
REQ-027: On out_valid && out_ready with in_valid=0, the block SHALL go to IDLE and deassert out_valid.
REQ-028: Mul rows not yet rewritten by the current job SHALL keep their previous values.
REQ-029: When NUM_ROWS=1, RUN lasts exactly one cycle.
REQ-030: Elaboration SHALL fail if ARRAY_SIZE is not a multiple of ROW_SIZE.

Reset
REQ-031: On rst_n=0, the block SHALL go to IDLE and clear the row counter; outputs Mul=0, sat_flag=0, out_valid=0, busy=0, in_ready=1.
REQ-032: Reset mid-RUN or in DONE SHALL abandon the job with no output handshake.
REQ-033: The first accept is possible on the first rising edge with rst_n=1.

Verification (defaults, NUM_ROWS=8)
REQ-034: All A elements = 3, B elements = -2, sat_mode=0, out_ready=1 -> out_valid rises 8 cycles after accept; every element = 0xFFFA; sat_flag=0.
REQ-035: Element 5: A=0x7FFF, B=2, sat_mode=1 -> element 5 = 0x7FFF, sat_flag=1; with sat_mode=0 -> element 5 = 0xFFFE, sat_flag=0.
REQ-036: out_ready held 0 for 5 cycles in DONE -> Mul, sat_flag and out_valid stay constant and in_ready=0; on release the result handshakes once.
REQ-037: Two jobs with in_valid held high and out_ready=1 -> second job accepted on the first job's output handshake edge; second out_valid 9 cycles after the first.
REQ-038: rst_n pulsed low during RUN row 4 -> outputs return to reset values immediately; the next job completes correctly.
REQ-039: A/B changed on every cycle after accept -> result reflects only the latched operands.
